// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, control enums and the pipeline control bundle
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef struct packed {
        logic        reg_w;
        result_src_e result_src;
        logic        mem_w;
        logic        alu_src;
        alu_op_e     alu_control;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        valid;
    } ctrl_bundle_t;

    // sub_alt selects SUB on funct3=000, sra_alt selects SRA on funct3=101
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3,
                                                input logic sub_alt,
                                                input logic sra_alt);
        case (f3)
            3'b000:  return sub_alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return sra_alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_pipeline_unit_decode.sv
// rtl/ctrl_pipeline_unit_decode.sv - combinational ID-stage decode into a control bundle
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t ctrl,
    output imm_src_e     imm_src,
    output logic         uses_rs1,
    output logic         uses_rs2,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign f3                = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15]};

    always_comb begin
        ctrl        = '0;
        imm_src     = IMM_I;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        illegal     = 1'b0;
        ctrl.rd     = instr[11:7];
        ctrl.funct3 = f3;
        ctrl.valid  = 1'b1;
        case (opcode)
            OP_R: begin
                ctrl.reg_w       = 1'b1;
                ctrl.alu_control = alu_from_funct3(f3, instr[30], instr[30]);
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
            end
            OP_I: begin
                ctrl.reg_w       = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = alu_from_funct3(f3, 1'b0, instr[30]);
                uses_rs1         = 1'b1;
            end
            OP_LOAD: begin
                ctrl.reg_w      = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.alu_src    = 1'b1;
                uses_rs1        = 1'b1;
            end
            OP_STORE: begin
                ctrl.mem_w   = 1'b1;
                ctrl.alu_src = 1'b1;
                imm_src      = IMM_S;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_control = ALU_SUB;
                imm_src          = IMM_B;
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
                // funct3 010/011 are not branches; EX resolves them as never taken
                illegal          = (f3[2:1] == 2'b01);
            end
            OP_JAL: begin
                ctrl.reg_w      = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jump       = 1'b1;
                imm_src         = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_w      = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jump       = 1'b1;
                ctrl.jalr       = 1'b1;
                ctrl.alu_src    = 1'b1;
                uses_rs1        = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                ctrl.reg_w   = 1'b1;
                ctrl.alu_src = 1'b1;
                imm_src      = IMM_U;
            end
            default: begin
                ctrl    = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipeline_unit.sv
// rtl/ctrl_pipeline_unit.sv - EX/MEM/WB control registers, branch resolution and hazard control
module ctrl_pipeline_unit
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int IMM_SRC_W  = 3,
    parameter bit HAZARD_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_d,
    input  logic                  hold,
    input  logic                  zero_e,
    input  logic                  lt_e,
    input  logic                  ltu_e,
    output logic [IMM_SRC_W-1:0]  imm_src_d,
    output logic                  illegal_d,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic                  alu_src_e,
    output logic                  pc_src_e,
    output logic                  jalr_e,
    output logic                  mem_w_m,
    output logic                  reg_w_m,
    output logic [4:0]            rd_m,
    output logic                  reg_w_w,
    output logic [1:0]            result_src_w,
    output logic [4:0]            rd_w,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d
);

    ctrl_bundle_t dec_ctrl;
    imm_src_e     dec_imm_src;
    logic         dec_uses_rs1;
    logic         dec_uses_rs2;

    ctrl_bundle_t ex_q, ex_d;
    ctrl_bundle_t mem_q, mem_d;
    ctrl_bundle_t wb_q, wb_d;

    logic branch_cond;
    logic load_use;
    logic unused_stage_bits;

    ctrl_decode u_decode (
        .instr    (instr_d),
        .ctrl     (dec_ctrl),
        .imm_src  (dec_imm_src),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .illegal  (illegal_d)
    );

    assign imm_src_d = IMM_SRC_W'(dec_imm_src);

    always_comb begin
        case (ex_q.funct3)
            3'b000:  branch_cond = zero_e;
            3'b001:  branch_cond = ~zero_e;
            3'b100:  branch_cond = lt_e;
            3'b101:  branch_cond = ~lt_e;
            3'b110:  branch_cond = ltu_e;
            3'b111:  branch_cond = ~ltu_e;
            default: branch_cond = 1'b0;
        endcase
    end

    assign pc_src_e = ex_q.valid & (ex_q.jump | (ex_q.branch & branch_cond));
    assign jalr_e   = ex_q.valid & ex_q.jalr;
    assign flush_d  = pc_src_e & ~hold;

    assign load_use = HAZARD_EN && ex_q.valid && (ex_q.result_src == RES_MEM)
                   && (ex_q.rd != 5'd0)
                   && ((dec_uses_rs1 && (instr_d[19:15] == ex_q.rd))
                    || (dec_uses_rs2 && (instr_d[24:20] == ex_q.rd)));

    // a redirect discards the ID instruction anyway, so it wins over the stall
    assign stall_f = HAZARD_EN && (hold || (load_use && !pc_src_e));
    assign stall_d = stall_f;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!hold) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (pc_src_e || load_use) begin
                ex_d = '0;
            end else begin
                ex_d = dec_ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign alu_control_e = ex_q.valid ? ALU_CTRL_W'(ex_q.alu_control) : '0;
    assign alu_src_e     = ex_q.valid & ex_q.alu_src;
    assign mem_w_m       = mem_q.valid & mem_q.mem_w;
    assign reg_w_m       = mem_q.valid & mem_q.reg_w;
    assign rd_m          = mem_q.valid ? mem_q.rd : 5'd0;
    assign reg_w_w       = wb_q.valid & wb_q.reg_w;
    assign result_src_w  = wb_q.valid ? wb_q.result_src : 2'b00;
    assign rd_w          = wb_q.valid ? wb_q.rd : 5'd0;

    assign unused_stage_bits = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_ctrl_pipeline_unit.sv
// tb/tb_ctrl_pipeline_unit.sv - scoreboard bench for ctrl_pipeline_unit
module tb_ctrl_pipeline_unit;

    logic        clk = 1'b0;
    logic        rst_n, hold, zero_e, lt_e, ltu_e;
    logic [31:0] instr_d;
    logic [2:0]  imm_src_d;
    logic        illegal_d;
    logic [3:0]  alu_control_e;
    logic        alu_src_e, pc_src_e, jalr_e, mem_w_m, reg_w_m, reg_w_w;
    logic [4:0]  rd_m, rd_w;
    logic [1:0]  result_src_w;
    logic        stall_f, stall_d, flush_d;

    ctrl_pipeline_unit dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .hold(hold),
        .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .imm_src_d(imm_src_d), .illegal_d(illegal_d),
        .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
        .pc_src_e(pc_src_e), .jalr_e(jalr_e), .mem_w_m(mem_w_m),
        .reg_w_m(reg_w_m), .rd_m(rd_m), .reg_w_w(reg_w_w),
        .result_src_w(result_src_w), .rd_w(rd_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d)
    );

    always #5 clk = ~clk;

    localparam int S_IMM = 0, S_ILL = 1, S_ALU = 2, S_ALUSRC = 3, S_PCSRC = 4,
                   S_JALR = 5, S_MEMWM = 6, S_REGWM = 7, S_RDM = 8, S_REGWW = 9,
                   S_RESW = 10, S_RDW = 11, S_STALLF = 12, S_STALLD = 13, S_FLUSH = 14;

    localparam logic [31:0] I_FILL  = 32'h0000_0000;
    localparam logic [31:0] I_ADD   = 32'h0020_81B3;
    localparam logic [31:0] I_SUB   = 32'h4020_8233;
    localparam logic [31:0] I_SRAI  = 32'h4030_D293;
    localparam logic [31:0] I_LUI   = 32'h1234_53B7;
    localparam logic [31:0] I_ADDI9 = 32'h0010_0493;
    localparam logic [31:0] I_BNE   = 32'h0020_9463;
    localparam logic [31:0] I_BGEU  = 32'h0020_F463;
    localparam logic [31:0] I_BADBR = 32'h0020_A463;
    localparam logic [31:0] I_LW5   = 32'h0000_A283;
    localparam logic [31:0] I_ADD6  = 32'h0072_8333;
    localparam logic [31:0] I_LW0   = 32'h0000_A003;
    localparam logic [31:0] I_ADD60 = 32'h0070_0333;
    localparam logic [31:0] I_SW    = 32'h0020_A023;
    localparam logic [31:0] I_JAL   = 32'h0100_00EF;
    localparam logic [31:0] I_JALR  = 32'h0002_80E7;
    localparam logic [31:0] I_ILL   = 32'h0000_007F;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] dut_val(input int s);
        case (s)
            S_IMM:    return 32'(imm_src_d);
            S_ILL:    return 32'(illegal_d);
            S_ALU:    return 32'(alu_control_e);
            S_ALUSRC: return 32'(alu_src_e);
            S_PCSRC:  return 32'(pc_src_e);
            S_JALR:   return 32'(jalr_e);
            S_MEMWM:  return 32'(mem_w_m);
            S_REGWM:  return 32'(reg_w_m);
            S_RDM:    return 32'(rd_m);
            S_REGWW:  return 32'(reg_w_w);
            S_RESW:   return 32'(result_src_w);
            S_RDW:    return 32'(rd_w);
            S_STALLF: return 32'(stall_f);
            S_STALLD: return 32'(stall_d);
            default:  return 32'(flush_d);
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            S_IMM:    return "imm_src_d";
            S_ILL:    return "illegal_d";
            S_ALU:    return "alu_control_e";
            S_ALUSRC: return "alu_src_e";
            S_PCSRC:  return "pc_src_e";
            S_JALR:   return "jalr_e";
            S_MEMWM:  return "mem_w_m";
            S_REGWM:  return "reg_w_m";
            S_RDM:    return "rd_m";
            S_REGWW:  return "reg_w_w";
            S_RESW:   return "result_src_w";
            S_RDW:    return "rd_w";
            S_STALLF: return "stall_f";
            S_STALLD: return "stall_d";
            default:  return "flush_d";
        endcase
    endfunction

    task automatic exp_at(input int off, input int sig, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc + off;
        e.sig = sig;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic step_f(input logic [31:0] i, input logic z, input logic l,
                          input logic lu, input logic h, input logic r);
        instr_d = i;
        zero_e  = z;
        lt_e    = l;
        ltu_e   = lu;
        hold    = h;
        rst_n   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [31:0] i);
        step_f(i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [31:0] act;
                act = dut_val(sb[i].sig);
                total++;
                if (act !== sb[i].val) begin
                    bad++;
                    $display("FAIL %s cycle %0d: got %0h expected %0h",
                             sig_name(sb[i].sig), cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        instr_d = I_FILL; zero_e = 0; lt_e = 0; ltu_e = 0; hold = 0; rst_n = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        total++;
        if (pc_src_e !== 1'b0) begin
            bad++;
            $display("FAIL direct pc_src_e after reset: got %0b", pc_src_e);
        end
        total++;
        if (mem_w_m !== 1'b0) begin
            bad++;
            $display("FAIL direct mem_w_m after reset: got %0b", mem_w_m);
        end
        total++;
        if (reg_w_w !== 1'b0) begin
            bad++;
            $display("FAIL direct reg_w_w after reset: got %0b", reg_w_w);
        end
        total++;
        if (flush_d !== 1'b0) begin
            bad++;
            $display("FAIL direct flush_d after reset: got %0b", flush_d);
        end
        total++;
        if (stall_d !== stall_f) begin
            bad++;
            $display("FAIL direct stall_d %0b differs from stall_f %0b", stall_d, stall_f);
        end

        exp_at(0, S_ALU, 0);   exp_at(0, S_ALUSRC, 0); exp_at(0, S_PCSRC, 0);
        exp_at(0, S_MEMWM, 0); exp_at(0, S_REGWM, 0);  exp_at(0, S_REGWW, 0);
        exp_at(0, S_RDW, 0);   exp_at(0, S_STALLF, 0); exp_at(0, S_FLUSH, 0);
        exp_at(0, S_ILL, 1);
        step(I_FILL);

        exp_at(0, S_ILL, 0);   exp_at(0, S_STALLF, 0); exp_at(1, S_ALU, 0);
        exp_at(1, S_ALUSRC, 0); exp_at(1, S_STALLF, 0); exp_at(2, S_REGWM, 1);
        exp_at(2, S_RDM, 3);   exp_at(3, S_REGWW, 1);  exp_at(3, S_RDW, 3);
        exp_at(3, S_RESW, 0);  exp_at(3, S_STALLF, 0);
        step(I_ADD);
        exp_at(1, S_ALU, 1);   exp_at(2, S_RDM, 4);
        step(I_SUB);
        exp_at(0, S_IMM, 0);   exp_at(1, S_ALU, 9);    exp_at(1, S_ALUSRC, 1);
        step(I_SRAI);
        exp_at(0, S_IMM, 4);   exp_at(1, S_ALU, 0);    exp_at(1, S_ALUSRC, 1);
        step(I_LUI);
        step(I_FILL); step(I_FILL); step(I_FILL);

        exp_at(0, S_IMM, 2);
        step(I_BNE);
        exp_at(0, S_PCSRC, 1); exp_at(0, S_FLUSH, 1);  exp_at(0, S_JALR, 0);
        exp_at(0, S_ALU, 1);   exp_at(1, S_ALUSRC, 0); exp_at(1, S_PCSRC, 0);
        exp_at(2, S_REGWM, 0);
        step_f(I_ADDI9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(I_FILL); step(I_FILL); step(I_FILL);

        step(I_BNE);
        exp_at(0, S_PCSRC, 0); exp_at(0, S_FLUSH, 0);  exp_at(1, S_ALUSRC, 1);
        exp_at(2, S_REGWM, 1); exp_at(2, S_RDM, 9);
        step_f(I_ADDI9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(I_FILL); step(I_FILL); step(I_FILL);

        exp_at(0, S_STALLF, 0);
        step(I_LW5);
        exp_at(0, S_STALLF, 1); exp_at(0, S_STALLD, 1); exp_at(0, S_ALUSRC, 1);
        exp_at(0, S_FLUSH, 0);
        step(I_ADD6);
        exp_at(0, S_STALLF, 0); exp_at(0, S_STALLD, 0); exp_at(0, S_ALUSRC, 0);
        exp_at(0, S_REGWM, 1);  exp_at(0, S_RDM, 5);
        step(I_ADD6);
        exp_at(0, S_STALLF, 0); exp_at(0, S_REGWM, 0);  exp_at(0, S_RESW, 1);
        exp_at(0, S_RDW, 5);    exp_at(1, S_REGWM, 1);  exp_at(1, S_RDM, 6);
        step(I_FILL);
        step(I_FILL); step(I_FILL); step(I_FILL);

        step(I_LW0);
        exp_at(0, S_STALLF, 0); exp_at(0, S_STALLD, 0); exp_at(1, S_REGWM, 1);
        exp_at(1, S_RDM, 0);    exp_at(2, S_REGWM, 1);  exp_at(2, S_RDM, 6);
        step(I_ADD60);
        step(I_FILL); step(I_FILL); step(I_FILL);

        exp_at(0, S_IMM, 2);
        step(I_BGEU);
        for (int k = 0; k < 3; k++) begin
            exp_at(0, S_PCSRC, 1); exp_at(0, S_FLUSH, 0);
            exp_at(0, S_STALLF, 1); exp_at(0, S_STALLD, 1);
            step_f(I_ADDI9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        exp_at(0, S_PCSRC, 1); exp_at(0, S_FLUSH, 1);  exp_at(0, S_STALLF, 0);
        exp_at(1, S_ALUSRC, 0); exp_at(1, S_PCSRC, 0); exp_at(2, S_REGWM, 0);
        step_f(I_ADDI9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(I_FILL); step(I_FILL); step(I_FILL);

        step(I_JALR);
        exp_at(0, S_PCSRC, 1); exp_at(0, S_JALR, 1);  exp_at(0, S_FLUSH, 1);
        exp_at(2, S_RESW, 2);  exp_at(2, S_RDW, 1);
        step(I_FILL);
        step(I_FILL); step(I_FILL); step(I_FILL);

        step(I_ADDI9);
        exp_at(0, S_ILL, 1);   exp_at(2, S_REGWM, 0);  exp_at(2, S_MEMWM, 0);
        exp_at(3, S_REGWW, 0);
        step(I_ILL);
        exp_at(0, S_ILL, 1);   exp_at(0, S_IMM, 2);
        step(I_BADBR);
        exp_at(0, S_PCSRC, 0); exp_at(0, S_FLUSH, 0);
        step_f(I_FILL, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(I_FILL); step(I_FILL); step(I_FILL);

        exp_at(0, S_IMM, 1);
        step(I_SW);
        exp_at(0, S_IMM, 3);
        step(I_JAL);
        exp_at(0, S_MEMWM, 1); exp_at(0, S_PCSRC, 1);
        step_f(I_FILL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        total++;
        if (mem_w_m !== 1'b0) begin
            bad++;
            $display("FAIL direct mem_w_m after mid-stream reset: got %0b", mem_w_m);
        end
        total++;
        if (pc_src_e !== 1'b0) begin
            bad++;
            $display("FAIL direct pc_src_e after mid-stream reset: got %0b", pc_src_e);
        end

        exp_at(0, S_MEMWM, 0); exp_at(0, S_PCSRC, 0);  exp_at(0, S_REGWM, 0);
        exp_at(0, S_FLUSH, 0); exp_at(0, S_REGWW, 0);  exp_at(1, S_REGWW, 0);
        step(I_FILL);
        step(I_FILL); step(I_FILL); step(I_FILL);

        while (sb.size() > 0) begin
            bad++;
            total++;
            $display("FAIL pending %s: expected %0h at cycle %0d never checked",
                     sig_name(sb[0].sig), sb[0].val, sb[0].cyc);
            sb.delete(0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
